aes_encipher_engine: RTL and testbench

AES_ENCIPHER_ENGINE -- requirements
Module: aes_encipher_engine

---
 rtl/aes_enc_pkg.sv | 65 ++++++
 rtl/aes_sbox.sv | 39 +++
 rtl/aes_encipher_engine.sv | 138 +++++++++++++
 tb/tb_aes_encipher_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_enc_pkg.sv
// Shared definitions for the AES encipher engine: key-length encodings, round
// counts, FSM state encoding and the GF(2^8) column/row transforms.
package aes_enc_pkg;

    localparam logic [1:0] KEYLEN_128 = 2'b00;
    localparam logic [1:0] KEYLEN_192 = 2'b01;
    localparam logic [1:0] KEYLEN_256 = 2'b10;

    localparam logic [3:0] ROUNDS_128 = 4'd10;
    localparam logic [3:0] ROUNDS_192 = 4'd12;
    localparam logic [3:0] ROUNDS_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SUB  = 2'd2,
        ST_RND  = 2'd3
    } aes_state_e;

    // 2'b11 is deliberately folded into the AES-256 round count.
    function automatic logic [3:0] num_rounds(input logic [1:0] kl);
        case (kl)
            KEYLEN_128: return ROUNDS_128;
            KEYLEN_192: return ROUNDS_192;
            default:    return ROUNDS_256;
        endcase
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            r[127 - 32*c -: 32] = mixw(s[127 - 32*c -: 32]);
        return r;
    endfunction

    // Byte 0 of the state sits in bits [127:120]; byte index is row + 4*column.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Four-byte AES S-box: multiplicative inverse in GF(2^8) followed by the
// standard affine transform, applied to each byte of a 32-bit word.
module aes_sbox
    import aes_enc_pkg::*;
(
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gm2(x);
        end
        return p;
    endfunction

    // x^254 is the inverse for non-zero x and maps 0 to 0.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign new_sboxw[8*i +: 8] = sub_byte(sboxw[8*i +: 8]);
    end

endmodule

// File: rtl/aes_encipher_engine.sv
// Iterative AES encipher datapath with an external key schedule and
// NUM_SBOX word S-box lanes. Optional abort input under AES_ENC_ABORT_EN.
//
// state | meaning
// IDLE  | ready=1, waiting for start; new_block holds last ciphertext
// INIT  | initial AddRoundKey of the plaintext with round key 0
// SUB   | SubBytes, NUM_SBOX words per cycle starting at w0
// RND   | ShiftRows, MixColumns (not in final round), AddRoundKey
module aes_encipher_engine
    import aes_enc_pkg::*;
#(
    parameter int NUM_SBOX = 4
)
(
    input  logic         clk,
    input  logic         reset_n,
`ifdef AES_ENC_ABORT_EN
    input  logic         abort,
`endif
    input  logic         start,
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         done
);

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4)) begin : g_bad_num_sbox
        $error("aes_encipher_engine: NUM_SBOX must be 1, 2 or 4");
    end

    localparam int SUB_CYCLES = 4 / NUM_SBOX;
    localparam int CNT_W      = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(SUB_CYCLES - 1);

    aes_state_e                  state_q;
    logic [127:0]                block_q;
    logic [3:0]                  round_q;
    logic                        ready_q;
    logic                        done_q;
    logic [CNT_W-1:0]            word_cnt;
    logic [1:0]                  keylen_q;

    logic [NUM_SBOX-1:0][31:0]   sbox_in;
    logic [NUM_SBOX-1:0][31:0]   sbox_out;
    logic [127:0]                sub_state;
    logic [127:0]                sr_state;
    logic [127:0]                rnd_state;
    logic                        last_round;

    for (genvar l = 0; l < NUM_SBOX; l++) begin : g_sbox
        assign sbox_in[l] = block_q[127 - 32*(int'(word_cnt)*NUM_SBOX + l) -: 32];
        aes_sbox u_sbox (
            .sboxw     (sbox_in[l]),
            .new_sboxw (sbox_out[l])
        );
    end

    always_comb begin
        sub_state = block_q;
        for (int l = 0; l < NUM_SBOX; l++)
            sub_state[127 - 32*(int'(word_cnt)*NUM_SBOX + l) -: 32] = sbox_out[l];
    end

    assign last_round = (round_q == num_rounds(keylen_q));
    assign sr_state   = shiftrows(block_q);
    assign rnd_state  = (last_round ? sr_state : mixcolumns(sr_state)) ^ round_key;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            block_q  <= '0;
            round_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            word_cnt <= '0;
            keylen_q <= KEYLEN_128;
        end
`ifdef AES_ENC_ABORT_EN
        else if (abort && state_q != ST_IDLE) begin
            state_q  <= ST_IDLE;
            block_q  <= '0;
            round_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            word_cnt <= '0;
        end
`endif
        else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        keylen_q <= keylen;
                        round_q  <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    block_q  <= block ^ round_key;
                    round_q  <= 4'd1;
                    word_cnt <= '0;
                    state_q  <= ST_SUB;
                end
                ST_SUB: begin
                    block_q <= sub_state;
                    if (word_cnt == LAST_WORD) begin
                        word_cnt <= '0;
                        state_q  <= ST_RND;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                ST_RND: begin
                    block_q <= rnd_state;
                    round_q <= round_q + 4'd1;
                    if (last_round) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_SUB;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign round     = round_q;
    assign new_block = block_q;
    assign ready     = ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_encipher_engine.sv
// Bench for aes_encipher_engine: three instances (NUM_SBOX 4/2/1) driven from a
// vector table, with an independent key-expansion model and a done scoreboard.
module tb_aes_encipher_engine;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        int           inst;
        logic [1:0]   kl;
        logic [255:0] key;
        logic [127:0] ct;
        bit           disturb;
        bit           abort_start;
    } vec_t;

    typedef struct {
        int           inst;
        logic [127:0] ct;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start     [3];
    logic [1:0]   keylen    [3];
    logic [3:0]   round     [3];
    logic [127:0] round_key [3];
    logic [127:0] block     [3];
    logic [127:0] new_block [3];
    logic         ready     [3];
    logic         done      [3];
`ifdef AES_ENC_ABORT_EN
    logic         abort     [3];
`endif
    logic [127:0] rks [3][16];

    int   checks = 0;
    int   failures = 0;
    int   done_cnt [3];
    exp_t sb [$];
    vec_t vecs [9];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NS = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        assign round_key[g] = rks[g][round[g]];
        aes_encipher_engine #(.NUM_SBOX(NS)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
`ifdef AES_ENC_ABORT_EN
            .abort     (abort[g]),
`endif
            .start     (start[g]),
            .keylen    (keylen[g]),
            .round     (round[g]),
            .round_key (round_key[g]),
            .block     (block[g]),
            .new_block (new_block[g]),
            .ready     (ready[g]),
            .done      (done[g])
        );
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse found by search, then the bitwise affine form of the S-box.
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        inv = 8'h00;
        c = 8'h63;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    task automatic expand(input int inst, input logic [1:0] kl, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = (kl == 2'b00) ? 4 : ((kl == 2'b01) ? 6 : 8);
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rks[inst][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // Scoreboard consumer: every done pulse must match a queued expectation.
    always @(posedge clk) begin
        exp_t x;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
                done_cnt[i]++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done inst=%0d actual=1 required=0", i);
                end else begin
                    x = sb.pop_front();
                    chk("done_inst", 128'(i), 128'(x.inst));
                    chk("ciphertext", new_block[i], x.ct);
                    chk("ready_at_done", 128'(ready[i]), 128'(1));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int nr, k, lat_exp, e, rmis, dc0;
        nr = (v.kl == 2'b00) ? 10 : ((v.kl == 2'b01) ? 12 : 14);
        k  = (v.inst == 0) ? 1 : ((v.inst == 1) ? 2 : 4);
        lat_exp = 1 + nr*(k+1);
        expand(v.inst, v.kl, v.key);
        @(negedge clk);
        block[v.inst]  = PT;
        keylen[v.inst] = v.kl;
        start[v.inst]  = 1'b1;
`ifdef AES_ENC_ABORT_EN
        abort[v.inst]  = v.abort_start;
`endif
        sb.push_back('{v.inst, v.ct});
        dc0 = done_cnt[v.inst];
        @(posedge clk); #1;
        start[v.inst] = 1'b0;
`ifdef AES_ENC_ABORT_EN
        abort[v.inst] = 1'b0;
`endif
        e = 0;
        rmis = (round[v.inst] !== 4'd0) ? 1 : 0;
        while (ready[v.inst] !== 1'b1 && e < 300) begin
            @(posedge clk); #1;
            e++;
            if (round[v.inst] !== 4'(1 + (e-1)/(k+1))) rmis++;
            if (v.disturb && e == 4) begin
                start[v.inst]  = 1'b1;
                keylen[v.inst] = ~v.kl;
                block[v.inst]  = ~PT;
            end else if (v.disturb && e == 5) begin
                start[v.inst]  = 1'b0;
                keylen[v.inst] = v.kl;
            end
        end
        chk("latency", 128'(e), 128'(lat_exp));
        chk("round_seq_errors", 128'(rmis), 128'(0));
        block[v.inst] = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", 128'(done_cnt[v.inst] - dc0), 128'(1));
        chk("hold_in_idle", new_block[v.inst], v.ct);
        chk("ready_idle", 128'(ready[v.inst]), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{0, 2'b00, K128, CT128, 1'b0, 1'b0};
        vecs[1] = '{1, 2'b01, K192, CT192, 1'b0, 1'b0};
        vecs[2] = '{2, 2'b10, K256, CT256, 1'b0, 1'b0};
        vecs[3] = '{0, 2'b10, K256, CT256, 1'b0, 1'b0};
        vecs[4] = '{1, 2'b00, K128, CT128, 1'b0, 1'b1};
        vecs[5] = '{2, 2'b01, K192, CT192, 1'b0, 1'b0};
        vecs[6] = '{1, 2'b11, K256, CT256, 1'b0, 1'b0};
        vecs[7] = '{0, 2'b00, K128, CT128, 1'b1, 1'b0};
        vecs[8] = '{2, 2'b10, K256, CT256, 1'b1, 1'b0};

        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            keylen[i] = 2'b00;
            block[i] = '0;
            done_cnt[i] = 0;
`ifdef AES_ENC_ABORT_EN
            abort[i] = 1'b0;
`endif
            for (int r = 0; r < 16; r++) rks[i][r] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", 128'(ready[i]), 128'(1));
            chk("reset_round", 128'(round[i]), 128'(0));
            chk("reset_new_block", new_block[i], 128'(0));
            chk("reset_done", 128'(done[i]), 128'(0));
        end
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of round 6 on the single-lane engine.
        expand(2, 2'b10, K256);
        @(negedge clk);
        block[2] = PT;
        keylen[2] = 2'b10;
        start[2] = 1'b1;
        @(posedge clk); #1;
        start[2] = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        chk("pre_reset_round", 128'(round[2]), 128'(6));
        reset_n = 1'b0;
        #1;
        chk("mid_reset_ready", 128'(ready[2]), 128'(1));
        chk("mid_reset_round", 128'(round[2]), 128'(0));
        chk("mid_reset_new_block", new_block[2], 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("post_reset_ready", 128'(ready[2]), 128'(1));
        chk("post_reset_new_block", new_block[2], 128'(0));
        run_vec(vecs[2]);

`ifdef AES_ENC_ABORT_EN
        // Abort in the SUB cycle of round 3.
        expand(0, 2'b00, K128);
        @(negedge clk);
        block[0] = PT;
        keylen[0] = 2'b00;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_abort_round", 128'(round[0]), 128'(3));
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_ready", 128'(ready[0]), 128'(1));
        chk("abort_round", 128'(round[0]), 128'(0));
        chk("abort_new_block", new_block[0], 128'(0));
        repeat (30) @(posedge clk);
        #1;
        chk("post_abort_ready", 128'(ready[0]), 128'(1));
        run_vec(vecs[0]);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_left", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
